// File: rtl/ysyx_23060191_wbc_if.sv
// Writeback-stage bus: EXU retire handshake, LSU read response, GPR/CSR write
// ports and the commit/fault status toward IFU and difftest.
interface ysyx_23060191_wbc_if #(
  parameter int XLEN = 32
);
  logic            i_exu_valid;
  logic            o_exu_ready;
  logic [XLEN-1:0] i_exu_res;
  logic [4:0]      i_rd_addr;
  logic            i_rd_wen;
  logic            i_load_en;
  logic            i_csr_res_en;
  logic [11:0]     i_csr_addr;
  logic [XLEN-1:0] i_csr_res;
  logic [XLEN-1:0] i_pc;
  logic [XLEN-1:0] i_dnpc;

  logic            i_lsu_rvalid;
  logic            o_lsu_rready;
  logic [XLEN-1:0] i_lsu_rdata;
  logic [1:0]      i_lsu_rresp;

  logic            o_rf_wen;
  logic [4:0]      o_rf_waddr;
  logic [XLEN-1:0] o_rf_wdata;
  logic            o_csr_wen;
  logic [11:0]     o_csr_waddr;
  logic [XLEN-1:0] o_csr_wdata;
  logic            o_commit_valid;
  logic [XLEN-1:0] o_commit_pc;
  logic [XLEN-1:0] o_commit_dnpc;
  logic            o_fault;
  logic            o_busy;

  modport slave (
    input  i_exu_valid, i_exu_res, i_rd_addr, i_rd_wen, i_load_en,
           i_csr_res_en, i_csr_addr, i_csr_res, i_pc, i_dnpc,
           i_lsu_rvalid, i_lsu_rdata, i_lsu_rresp,
    output o_exu_ready, o_lsu_rready, o_rf_wen, o_rf_waddr, o_rf_wdata,
           o_csr_wen, o_csr_waddr, o_csr_wdata, o_commit_valid,
           o_commit_pc, o_commit_dnpc, o_fault, o_busy
  );

  modport master (
    output i_exu_valid, i_exu_res, i_rd_addr, i_rd_wen, i_load_en,
           i_csr_res_en, i_csr_addr, i_csr_res, i_pc, i_dnpc,
           i_lsu_rvalid, i_lsu_rdata, i_lsu_rresp,
    input  o_exu_ready, o_lsu_rready, o_rf_wen, o_rf_waddr, o_rf_wdata,
           o_csr_wen, o_csr_waddr, o_csr_wdata, o_commit_valid,
           o_commit_pc, o_commit_dnpc, o_fault, o_busy
  );
endinterface

// File: rtl/ysyx_23060191_wbc.sv
// Writeback controller: latches one retiring instruction, waits for load data
// (bounded by LD_TIMEOUT), then drives the GPR/CSR write ports and commit for one cycle.
module ysyx_23060191_wbc #(
  parameter int XLEN       = 32,
  parameter int LD_TIMEOUT = 255
) (
  input logic                    i_clk,
  input logic                    i_rst_n,
  ysyx_23060191_wbc_if.slave     bus
);
  typedef enum logic [1:0] {IDLE, WAIT_LD, WRITE} state_e;

  localparam logic [15:0] CNT_LAST = 16'(LD_TIMEOUT - 1);

  state_e          state_q, state_d;
  logic [15:0]     cnt_q, cnt_d;
  logic            err_q, err_d;

  logic [XLEN-1:0] exu_res_q, rdata_q, csr_res_q, pc_q, dnpc_q;
  logic [4:0]      rd_q;
  logic [11:0]     csr_addr_q;
  logic            rd_wen_q, load_q, csr_en_q;

  logic exu_hs, lsu_hs, in_write;

  // Readies depend on state alone so no input can loop back combinationally.
  assign bus.o_exu_ready  = (state_q == IDLE);
  assign bus.o_lsu_rready = (state_q == WAIT_LD);
  assign exu_hs   = bus.i_exu_valid  & bus.o_exu_ready;
  assign lsu_hs   = bus.i_lsu_rvalid & bus.o_lsu_rready;
  assign in_write = (state_q == WRITE);

  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (exu_hs) begin
          state_d = bus.i_load_en ? WAIT_LD : WRITE;
          cnt_d   = '0;
          err_d   = 1'b0;
        end
      end
      WAIT_LD: begin
        if (lsu_hs) begin
          err_d   = |bus.i_lsu_rresp;
          state_d = WRITE;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          state_d = WRITE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      WRITE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // NOTE: latched fields are reset too, so address/data/pc outputs read 0 in reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      exu_res_q  <= '0;
      rd_q       <= '0;
      rd_wen_q   <= 1'b0;
      load_q     <= 1'b0;
      csr_en_q   <= 1'b0;
      csr_addr_q <= '0;
      csr_res_q  <= '0;
      pc_q       <= '0;
      dnpc_q     <= '0;
      rdata_q    <= '0;
    end else begin
      if (exu_hs) begin
        exu_res_q  <= bus.i_exu_res;
        rd_q       <= bus.i_rd_addr;
        rd_wen_q   <= bus.i_rd_wen;
        load_q     <= bus.i_load_en;
        csr_en_q   <= bus.i_csr_res_en;
        csr_addr_q <= bus.i_csr_addr;
        csr_res_q  <= bus.i_csr_res;
        pc_q       <= bus.i_pc;
        dnpc_q     <= bus.i_dnpc;
      end
      if (lsu_hs) rdata_q <= bus.i_lsu_rdata;
    end
  end

  assign bus.o_rf_wen       = in_write & rd_wen_q & (rd_q != 5'd0) & ~err_q;
  assign bus.o_rf_waddr     = rd_q;
  assign bus.o_rf_wdata     = load_q ? rdata_q : exu_res_q;
  assign bus.o_csr_wen      = in_write & csr_en_q & ~err_q;
  assign bus.o_csr_waddr    = csr_addr_q;
  assign bus.o_csr_wdata    = csr_res_q;
  assign bus.o_commit_valid = in_write;
  assign bus.o_commit_pc    = pc_q;
  assign bus.o_commit_dnpc  = dnpc_q;
  assign bus.o_fault        = in_write & err_q;
  assign bus.o_busy         = (state_q != IDLE);
endmodule

// File: tb/tb_ysyx_23060191_wbc.sv
// Bench for ysyx_23060191_wbc: directed vector table, randomized transactions
// scored by a cycle-offset reference model, and reset corner sequences.
module tb_ysyx_23060191_wbc;
  localparam int XLEN = 32;
  localparam int T    = 4;
  localparam int NEVER = 255;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ysyx_23060191_wbc_if #(.XLEN(XLEN)) bus ();

  ysyx_23060191_wbc #(.XLEN(XLEN), .LD_TIMEOUT(T)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus.slave)
  );

  // Inputs, then expectations: lat = period of the commit, counted from the
  // EXU handshake period (0).
  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        rd_wen;
    logic        load;
    logic        csr_en;
    logic [11:0] csr_addr;
    logic [31:0] csr_res;
    logic [31:0] pc;
    logic [31:0] dnpc;
    int          delay;
    logic [1:0]  resp;
    logic [31:0] rdata;
    int          lat;
    logic        rf_wen;
    logic        csr_wen;
    logic        fault;
  } vec_t;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference rules: non-load commits next cycle; a load commits one cycle after
  // the response, or LD_TIMEOUT cycles after entering the wait with a fault.
  function automatic vec_t make_rand();
    vec_t v;
    logic err;
    v.res      = $urandom;
    v.rd       = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
    v.rd_wen   = 1'($urandom_range(0, 3) != 0);
    v.load     = 1'($urandom_range(0, 1));
    v.csr_en   = 1'($urandom_range(0, 3) == 0);
    v.csr_addr = 12'($urandom);
    v.csr_res  = $urandom;
    v.pc       = {$urandom_range(0, 32'h3fff_ffff), 2'b00};
    v.dnpc     = v.pc + 32'd4;
    v.delay    = ($urandom_range(0, 5) == 0) ? NEVER : $urandom_range(0, 6);
    v.resp     = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
    v.rdata    = $urandom;
    if (!v.load) begin
      v.lat = 1; err = 1'b0;
    end else if (v.delay < T) begin
      v.lat = v.delay + 2; err = (v.resp != 2'd0);
    end else begin
      v.lat = 1 + T; err = 1'b1;
    end
    v.rf_wen  = v.rd_wen && (v.rd != 5'd0) && !err;
    v.csr_wen = v.csr_en && !err;
    v.fault   = err;
    return v;
  endfunction

  task automatic idle_inputs();
    bus.i_exu_valid  = 1'b0;
    bus.i_exu_res    = '0;
    bus.i_rd_addr    = '0;
    bus.i_rd_wen     = 1'b0;
    bus.i_load_en    = 1'b0;
    bus.i_csr_res_en = 1'b0;
    bus.i_csr_addr   = '0;
    bus.i_csr_res    = '0;
    bus.i_pc         = '0;
    bus.i_dnpc       = '0;
    bus.i_lsu_rvalid = 1'b0;
    bus.i_lsu_rdata  = '0;
    bus.i_lsu_rresp  = '0;
  endtask

  task automatic drive_exu(input vec_t v);
    bus.i_exu_valid  = 1'b1;
    bus.i_exu_res    = v.res;
    bus.i_rd_addr    = v.rd;
    bus.i_rd_wen     = v.rd_wen;
    bus.i_load_en    = v.load;
    bus.i_csr_res_en = v.csr_en;
    bus.i_csr_addr   = v.csr_addr;
    bus.i_csr_res    = v.csr_res;
    bus.i_pc         = v.pc;
    bus.i_dnpc       = v.dnpc;
  endtask

  // Called just after a rising edge with the DUT idle; returns the same way.
  task automatic run_txn(input vec_t v, input string tag);
    bit seen = 0;
    drive_exu(v);
    bus.i_lsu_rvalid = 1'b1;            // IDLE-cycle response must be ignored
    bus.i_lsu_rdata  = $urandom;
    bus.i_lsu_rresp  = 2'd3;
    @(negedge clk);
    check({tag, ".ready_idle"}, 64'(bus.o_exu_ready), 64'd1);
    @(posedge clk); #1;
    bus.i_exu_valid = 1'b0;
    bus.i_exu_res   = $urandom;
    bus.i_rd_addr   = 5'($urandom);
    bus.i_pc        = $urandom;
    for (int p = 1; p <= 20 && !seen; p++) begin
      if (v.load && p == 1 + v.delay && p < v.lat) begin
        bus.i_lsu_rvalid = 1'b1;
        bus.i_lsu_rdata  = v.rdata;
        bus.i_lsu_rresp  = v.resp;
      end else begin
        bus.i_lsu_rvalid = (p == v.lat);  // response during WRITE must be ignored
        bus.i_lsu_rdata  = $urandom;
        bus.i_lsu_rresp  = 2'($urandom);
      end
      @(negedge clk);
      if (bus.o_commit_valid) begin
        seen = 1;
        check({tag, ".lat"},     64'(p),                  64'(v.lat));
        check({tag, ".rf_wen"},  64'(bus.o_rf_wen),       64'(v.rf_wen));
        if (v.rf_wen) begin
          check({tag, ".rf_waddr"}, 64'(bus.o_rf_waddr),  64'(v.rd));
          check({tag, ".rf_wdata"}, 64'(bus.o_rf_wdata),  64'(v.load ? v.rdata : v.res));
        end
        check({tag, ".csr_wen"}, 64'(bus.o_csr_wen),      64'(v.csr_wen));
        if (v.csr_wen) begin
          check({tag, ".csr_waddr"}, 64'(bus.o_csr_waddr), 64'(v.csr_addr));
          check({tag, ".csr_wdata"}, 64'(bus.o_csr_wdata), 64'(v.csr_res));
        end
        check({tag, ".fault"},   64'(bus.o_fault),        64'(v.fault));
        check({tag, ".pc"},      64'(bus.o_commit_pc),    64'(v.pc));
        check({tag, ".dnpc"},    64'(bus.o_commit_dnpc),  64'(v.dnpc));
      end
      @(posedge clk); #1;
    end
    if (!seen) check({tag, ".commit_seen"}, 64'd0, 64'd1);
    bus.i_lsu_rvalid = 1'b0;
    @(negedge clk);
    check({tag, ".ready_after"}, 64'({bus.o_exu_ready, bus.o_commit_valid, bus.o_rf_wen}), 64'b100);
    @(posedge clk); #1;
  endtask

  vec_t tbl[8];

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //          res           rd     wen  ld   csr  caddr    cres          pc            dnpc          dly    rsp   rdata         lat  rfw  csrw flt
    tbl[0] = '{32'h1234_5678, 5'd5,  1'b1,1'b0,1'b0,12'h000, 32'h0,        32'h8000_0000,32'h8000_0004,0,     2'd0, 32'h0,        1,   1'b1,1'b0,1'b0};
    tbl[1] = '{32'hdead_beef, 5'd0,  1'b1,1'b0,1'b1,12'h305, 32'h8000_0100,32'h8000_0010,32'h8000_0014,0,     2'd0, 32'h0,        1,   1'b0,1'b1,1'b0};
    tbl[2] = '{32'h0000_1111, 5'd10, 1'b1,1'b1,1'b0,12'h000, 32'h0,        32'h8000_0020,32'h8000_0024,3,     2'd0, 32'hffff_ff80,5,   1'b1,1'b0,1'b0};
    tbl[3] = '{32'h0000_2222, 5'd11, 1'b1,1'b1,1'b0,12'h000, 32'h0,        32'h8000_0030,32'h8000_0034,1,     2'd2, 32'h5555_aaaa,3,   1'b0,1'b0,1'b1};
    tbl[4] = '{32'h0000_3333, 5'd12, 1'b1,1'b1,1'b0,12'h000, 32'h0,        32'h8000_0040,32'h8000_0044,NEVER, 2'd0, 32'h0,        5,   1'b0,1'b0,1'b1};
    tbl[5] = '{32'h0000_4444, 5'd13, 1'b1,1'b1,1'b0,12'h000, 32'h0,        32'h8000_0050,32'h8000_0054,3,     2'd0, 32'h0bad_cafe,5,   1'b1,1'b0,1'b0};
    tbl[6] = '{32'h0000_5555, 5'd14, 1'b0,1'b1,1'b0,12'h000, 32'h0,        32'h8000_0060,32'h8000_0064,0,     2'd0, 32'h7777_7777,2,   1'b0,1'b0,1'b0};
    tbl[7] = '{32'h0000_6666, 5'd15, 1'b1,1'b1,1'b1,12'h341, 32'h1234_0000,32'h8000_0070,32'h8000_0074,2,     2'd1, 32'h9999_9999,4,   1'b0,1'b0,1'b1};

    idle_inputs();
    rst_n = 1'b0;
    #1;
    check("rst.strobes", 64'({bus.o_rf_wen, bus.o_csr_wen, bus.o_commit_valid, bus.o_fault,
                              bus.o_busy, bus.o_lsu_rready}), 64'd0);
    check("rst.fields", 64'({bus.o_rf_waddr, bus.o_csr_waddr}) | 64'(bus.o_commit_pc)
                        | 64'(bus.o_rf_wdata), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst.ready", 64'(bus.o_exu_ready), 64'd1);

    foreach (tbl[i]) run_txn(tbl[i], $sformatf("vec%0d", i));

    // Reset while waiting for load data drops the instruction.
    drive_exu(tbl[2]);
    @(posedge clk); #1;
    bus.i_exu_valid = 1'b0;
    @(posedge clk); #1;
    check("rstld.busy", 64'({bus.o_busy, bus.o_lsu_rready}), 64'b11);
    rst_n = 1'b0;
    #1;
    check("rstld.out", 64'({bus.o_busy, bus.o_lsu_rready, bus.o_commit_valid, bus.o_rf_wen}), 64'd0);
    check("rstld.fields", 64'(bus.o_commit_pc) | 64'(bus.o_rf_waddr), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    begin
      int commits = 0;
      bus.i_lsu_rvalid = 1'b1;
      bus.i_lsu_rdata  = 32'h1357_9bdf;
      repeat (6) begin
        @(negedge clk);
        if (bus.o_commit_valid) commits++;
      end
      check("rstld.no_commit", 64'(commits), 64'd0);
      bus.i_lsu_rvalid = 1'b0;
    end
    @(posedge clk); #1;
    run_txn(tbl[0], "after_rst");

    for (int i = 0; i < 40; i++) run_txn(make_rand(), $sformatf("rnd%0d", i));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
